gfau_arbiter: RTL and testbench
===============================

GFAU_ARBITER -- requirements
Module: gfau_arbiter

Interface
REQ-001 Parameter SIZE, default 32, operand/result width in bits.
REQ-002 Parameter TIMEOUT, default 1023, maximum WAIT cycles before abort; a TIMEOUT-cycle watchdog counter is 10 bits at the default.
REQ-003 i_clk  in  1  single clock; all state updates on rising edge.
REQ-004 i_rst  in  1  reset, asynchronous, active-low.
REQ-005 req_0 / req_1  in  1  request from requester 0 / 1, level, held until its done pulse.
REQ-006 op_0 / op_1  in  2  operation: 0 add, 1 sub, 2 mult, 3 div.
REQ-007 a_0, b_0, p_0 / a_1, b_1, p_1  in  SIZE  operands and prime per requester.
REQ-008 done_0 / done_1  out  1  one-cycle completion pulse to requester 0 / 1.
REQ-009 err_0 / err_1  out  1  valid with done_k; 1 = aborted (div-by-zero or timeout).
REQ-010 result_0 / result_1  out  SIZE  registered result, held until that requester's next done.
REQ-011 gf_in_0, gf_in_1, gf_prime  out  SIZE  operands driven to the GFAU.
REQ-012 gf_op  out  2  operation_select to the GFAU.
REQ-013 gf_start  out  1  done_from_control to the GFAU, one-cycle start pulse.
REQ-014 gf_result  in  SIZE  GFAU result.
REQ-015 gf_done  in  1  GFAU done_to_control, sampled only in WAIT.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, RESP; one-hot or binary, implementer's choice.
REQ-018 IDLE: if any req_k high, grant one requester, latch its op/a/b/p into gf_* registers, go ISSUE.
REQ-019 Arbitration: round-robin; on simultaneous req_0 and req_1, grant the requester not granted last; pointer favors 0 after reset.
REQ-020 Div-by-zero: granted op=3 with b=0 (mod nothing checked) skips ISSUE/WAIT, goes directly to RESP with err=1, result=0; pointer still advances.
REQ-021 ISSUE: gf_start=1 for exactly this one cycle; watchdog cleared; go WAIT.
REQ-022 WAIT: on gf_done=1 capture gf_result into result_k, err_k=0, go RESP; else increment watchdog.
REQ-023 Watchdog reaching TIMEOUT without gf_done: go RESP with err_k=1, result_k=0; gf_done in the same cycle as expiry wins (normal completion).
REQ-024 RESP: done_k=1 and err_k valid for one cycle for the granted requester only; go IDLE.
REQ-025 Latency: req sampled at edge N -> gf_start high in cycle N+1; gf_done sampled at edge M -> done_k high in cycle M+1; div-by-zero done_k in cycle N+1.
REQ-026 gf_in_0/gf_in_1/gf_prime/gf_op stable from ISSUE through WAIT; requester operand changes after grant are ignored.
REQ-027 req_k dropped after grant does not cancel; the operation completes and done_k still pulses.
REQ-028 req_k still high in the cycle after done_k is a new request; IDLE re-arbitrates, so round-robin alternates under contention.
REQ-029 gf_done outside WAIT is ignored.
REQ-030 No new grant while busy; a maximum of one operation outstanding.

Reset
REQ-031 i_rst low asynchronously forces IDLE, gf_start=0, done_k=0, err_k=0, result_k=0, gf_* = 0, busy=0, watchdog=0, pointer favoring requester 0.
REQ-032 Reset mid-operation (ISSUE/WAIT/RESP) aborts without any done_k pulse; first request after release is arbitrated fresh.

Verification
REQ-033 req_0 only, op=2, a=86, b=53, p=97, GFAU model done after 5 cycles -> one gf_start pulse, done_0 with result_0=96, err_0=0, done_1 never high.
REQ-034 req_0 and req_1 asserted together, held high for 4 operations -> grants order 0,1,0,1; each done pulse matches its own requester's operands.
REQ-035 req_1 op=3, b=0 -> no gf_start, done_1 next cycle, err_1=1, result_1=0.
REQ-036 GFAU model never raises gf_done, TIMEOUT=8 -> done_k exactly 8 WAIT cycles after ISSUE, err_k=1; gf_done forced on expiry cycle -> err_k=0, result captured.
REQ-037 i_rst low during WAIT -> all outputs 0 immediately, no done pulse; after release, req_1 alone is granted and completes normally.
REQ-038 op=0, a=86, b=53, p=97 then op=1 same operands -> result 42 then 33.

Source files
------------

// File: rtl/gfau_arbiter_if.sv
// GFAU-side bus of the arbiter: operands, opcode and the start/done handshake.
interface gfau_arbiter_if #(
  parameter int SIZE = 32
);
  logic [SIZE-1:0] gf_in_0;
  logic [SIZE-1:0] gf_in_1;
  logic [SIZE-1:0] gf_prime;
  logic [1:0]      gf_op;
  logic            gf_start;
  logic [SIZE-1:0] gf_result;
  logic            gf_done;

  modport master (
    output gf_in_0, gf_in_1, gf_prime, gf_op, gf_start,
    input  gf_result, gf_done
  );

  modport slave (
    input  gf_in_0, gf_in_1, gf_prime, gf_op, gf_start,
    output gf_result, gf_done
  );
endinterface

// File: rtl/gfau_arbiter.sv
// Two-requester round-robin front end for a single GFAU, with div-by-zero
// short-circuit and a watchdog that aborts a GFAU that never answers.
module gfau_arbiter #(
  parameter int SIZE    = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            req_0,
  input  logic            req_1,
  input  logic [1:0]      op_0,
  input  logic [1:0]      op_1,
  input  logic [SIZE-1:0] a_0,
  input  logic [SIZE-1:0] b_0,
  input  logic [SIZE-1:0] p_0,
  input  logic [SIZE-1:0] a_1,
  input  logic [SIZE-1:0] b_1,
  input  logic [SIZE-1:0] p_1,
  output logic            done_0,
  output logic            done_1,
  output logic            err_0,
  output logic            err_1,
  output logic [SIZE-1:0] result_0,
  output logic [SIZE-1:0] result_1,
  output logic            busy,
  gfau_arbiter_if.master  gf
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [WD_W-1:0] wd;
  logic            last_1;
  logic            owner;

  logic            grant_1;
  logic [1:0]      g_op;
  logic [SIZE-1:0] g_a, g_b, g_p;
  logic            div0;
  logic            fin;
  logic            fin_k;
  logic            fin_err;
  logic [SIZE-1:0] fin_res;

  // Contention goes to whoever was not granted last; last_1 resets to 1 so 0 wins first.
  always_comb begin
    grant_1 = req_1 & (~req_0 | ~last_1);
    g_op    = grant_1 ? op_1 : op_0;
    g_a     = grant_1 ? a_1  : a_0;
    g_b     = grant_1 ? b_1  : b_0;
    g_p     = grant_1 ? p_1  : p_0;
    div0    = (g_op == 2'd3) && (g_b == '0);
  end

  // Single completion path shared by div-by-zero, normal finish and timeout.
  always_comb begin
    fin     = 1'b0;
    fin_k   = owner;
    fin_err = 1'b0;
    fin_res = '0;
    case (state)
      IDLE: if ((req_0 | req_1) && div0) begin
        fin     = 1'b1;
        fin_k   = grant_1;
        fin_err = 1'b1;
      end
      WAIT: if (gf.gf_done) begin
        fin     = 1'b1;
        fin_res = gf.gf_result;
      end else if (wd == WD_W'(TIMEOUT - 1)) begin
        fin     = 1'b1;
        fin_err = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= IDLE;
      wd          <= '0;
      last_1      <= 1'b1;
      owner       <= 1'b0;
      done_0      <= 1'b0;
      done_1      <= 1'b0;
      err_0       <= 1'b0;
      err_1       <= 1'b0;
      result_0    <= '0;
      result_1    <= '0;
      gf.gf_in_0  <= '0;
      gf.gf_in_1  <= '0;
      gf.gf_prime <= '0;
      gf.gf_op    <= '0;
      gf.gf_start <= 1'b0;
    end else begin
      done_0      <= 1'b0;
      done_1      <= 1'b0;
      err_0       <= 1'b0;
      err_1       <= 1'b0;
      gf.gf_start <= 1'b0;

      if (fin) begin
        if (fin_k) begin
          done_1   <= 1'b1;
          err_1    <= fin_err;
          result_1 <= fin_res;
        end else begin
          done_0   <= 1'b1;
          err_0    <= fin_err;
          result_0 <= fin_res;
        end
      end

      case (state)
        IDLE: if (req_0 | req_1) begin
          owner       <= grant_1;
          last_1      <= grant_1;
          gf.gf_in_0  <= g_a;
          gf.gf_in_1  <= g_b;
          gf.gf_prime <= g_p;
          gf.gf_op    <= g_op;
          if (div0) begin
            state <= RESP;
          end else begin
            gf.gf_start <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (fin) state <= RESP;
          else     wd    <= wd + 1'b1;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_gfau_arbiter.sv
// Directed bench for gfau_arbiter with a small behavioural GFAU (mod-p add/sub/mult/div).
module tb_gfau_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        req_0 = 1'b0, req_1 = 1'b0;
  logic [1:0]  op_0 = '0, op_1 = '0;
  logic [31:0] a_0 = '0, b_0 = '0, p_0 = '0, a_1 = '0, b_1 = '0, p_1 = '0;
  logic        done_0, done_1, err_0, err_1, busy;
  logic [31:0] result_0, result_1;

  gfau_arbiter_if #(.SIZE(32)) gf ();

  gfau_arbiter #(.SIZE(32), .TIMEOUT(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .req_0(req_0), .req_1(req_1), .op_0(op_0), .op_1(op_1),
    .a_0(a_0), .b_0(b_0), .p_0(p_0), .a_1(a_1), .b_1(b_1), .p_1(p_1),
    .done_0(done_0), .done_1(done_1), .err_0(err_0), .err_1(err_1),
    .result_0(result_0), .result_1(result_1), .busy(busy), .gf(gf)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int start_cnt = 0, d0_cnt = 0, d1_cnt = 0;
  int model_delay = 5;
  bit model_never = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  always @(negedge i_clk) begin
    if (gf.gf_start) start_cnt++;
    if (done_0) d0_cnt++;
    if (done_1) d1_cnt++;
  end

  // GFAU model: answers model_delay cycles after the start pulse.
  initial begin
    longint unsigned x, y, m, r;
    gf.gf_done   = 1'b0;
    gf.gf_result = '0;
    forever begin
      @(negedge i_clk);
      if (gf.gf_start && !model_never) begin
        x = gf.gf_in_0; y = gf.gf_in_1; m = gf.gf_prime; r = 0;
        case (gf.gf_op)
          2'd0: r = (x + y) % m;
          2'd1: r = (x + m - y) % m;
          2'd2: r = (x * y) % m;
          default: for (longint unsigned i = 1; i < m; i++) if ((y * i) % m == 1) r = (x * i) % m;
        endcase
        repeat (model_delay) @(negedge i_clk);
        gf.gf_result = 32'(r);
        gf.gf_done   = 1'b1;
        @(negedge i_clk);
        gf.gf_done   = 1'b0;
      end
    end
  end

  task automatic do_op(input string tag, input bit k, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                       input logic [31:0] exp_res, input bit exp_err, input int exp_lat,
                       input int exp_starts, input bit drop);
    int s0, oth, lat;
    bit seen;
    s0  = start_cnt;
    oth = k ? d0_cnt : d1_cnt;
    if (k) begin req_1 = 1'b1; op_1 = op; a_1 = a; b_1 = b; p_1 = p; end
    else   begin req_0 = 1'b1; op_0 = op; a_0 = a; b_0 = b; p_0 = p; end
    lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      step();
      lat++;
      if (lat == 1) begin
        check({tag, "_busy"}, busy, 1);
        if (k) begin a_1 = ~a; b_1 = '0; op_1 = 2'd3; end
        else   begin a_0 = ~a; b_0 = '0; op_0 = 2'd3; end
        if (drop) begin req_0 = 1'b0; req_1 = 1'b0; end
      end
      if (lat == 3 && exp_starts == 1) check({tag, "_gf_in_0_stable"}, gf.gf_in_0, a);
      if (k ? done_1 : done_0) seen = 1'b1;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_err"}, k ? err_1 : err_0, exp_err);
    check({tag, "_result"}, k ? result_1 : result_0, exp_res);
    req_0 = 1'b0; req_1 = 1'b0;
    step();
    check({tag, "_done_pulse_width"}, k ? done_1 : done_0, 0);
    check({tag, "_starts"}, start_cnt - s0, exp_starts);
    check({tag, "_other_done"}, k ? d0_cnt : d1_cnt, oth);
  endtask

  initial begin
    int got, d0s, d1s;
    step();
    check("rst_busy", busy, 0);
    check("rst_done", {done_0, done_1, err_0, err_1}, 0);
    check("rst_results", {result_0, result_1}, 0);
    check("rst_gf_bus", {gf.gf_in_0, gf.gf_prime, gf.gf_op, gf.gf_start}, 0);
    i_rst = 1'b1;
    step();

    do_op("mult", 1'b0, 2'd2, 86, 53, 97, 96, 1'b0, 7, 1, 1'b0);
    do_op("add",  1'b0, 2'd0, 86, 53, 97, 42, 1'b0, 7, 1, 1'b1);
    do_op("sub",  1'b0, 2'd1, 86, 53, 97, 33, 1'b0, 7, 1, 1'b0);
    do_op("div0", 1'b1, 2'd3, 5,  0,  97, 0,  1'b1, 1, 0, 1'b0);
    check("div0_busy_after", busy, 0);

    // Reset during WAIT: everything clears at once and no done ever appears.
    req_0 = 1'b1; op_0 = 2'd0; a_0 = 1; b_0 = 1; p_0 = 97;
    repeat (3) step();
    d0s = d0_cnt; d1s = d1_cnt;
    i_rst = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_outputs", {gf.gf_start, done_0, err_0, gf.gf_op}, 0);
    check("midrst_result_0", result_0, 0);
    check("midrst_gf_in_0", gf.gf_in_0, 0);
    req_0 = 1'b0;
    repeat (2) step();
    i_rst = 1'b1;
    repeat (10) step();
    check("midrst_no_done", (d0_cnt - d0s) + (d1_cnt - d1s), 0);

    do_op("after_rst_req1", 1'b1, 2'd0, 1, 2, 97, 3, 1'b0, 7, 1, 1'b0);

    // Contention with both requests held: grants must alternate 0,1,0,1.
    req_0 = 1'b1; op_0 = 2'd0; a_0 = 10; b_0 = 20; p_0 = 97;
    req_1 = 1'b1; op_1 = 2'd2; a_1 = 10; b_1 = 20; p_1 = 97;
    got = 0;
    for (int t = 0; t < 200 && got < 4; t++) begin
      step();
      if (done_0 || done_1) begin
        check("rr_onehot", done_0 ^ done_1, 1);
        check("rr_order", done_1, got % 2);
        check("rr_result", done_1 ? result_1 : result_0, done_1 ? 6 : 30);
        got++;
        if (got == 4) begin req_0 = 1'b0; req_1 = 1'b0; end
      end
    end
    check("rr_count", got, 4);
    repeat (2) step();

    model_never = 1'b1;
    do_op("timeout", 1'b0, 2'd0, 50, 60, 97, 0, 1'b1, 10, 1, 1'b0);
    model_never = 1'b0;
    model_delay = 8;
    do_op("expiry_done_wins", 1'b0, 2'd0, 50, 60, 97, 13, 1'b0, 10, 1, 1'b0);
    check("result_1_held", result_1, 6);
    check("final_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
